// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and widths for the sram port arbiter
package sram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, SLOT, SAMPLE, GAP} state_t;

  typedef enum logic {PORT_A, PORT_B} port_sel_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } req_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - request/ack port bundle for one arbiter client
interface sram_port_if;
  import sram_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              ack;
  logic              busy;

  modport master (output req, we, addr, din, input dout, ack, busy);
  modport slave  (input req, we, addr, din, output dout, ack, busy);

endinterface

// File: rtl/sram_arb_port.sv
// rtl/sram_arb_port.sv - per-port pending request, busy flag, read-data latch and ack
module sram_arb_port
  import sram_arb_pkg::*;
(
  input  logic              clk_sdram,
  input  logic              init_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              grant_done,
  input  logic [DATA_W-1:0] sample_data,
  output req_t              pend,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              ack
);

  // Capture a strobe when idle; on completion clear pending, pulse ack, latch read data.
  always_ff @(posedge clk_sdram) begin
    if (!init_n) begin
      pend <= '0;
      busy <= 1'b0;
      dout <= '0;
      ack  <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (req && !busy) begin
        pend <= '{we: we, addr: addr, din: din};
        busy <= 1'b1;
      end else if (grant_done) begin
        busy <= 1'b0;
        ack  <= 1'b1;
        if (!pend.we) begin
          dout <= sample_data;
        end
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port serialiser onto the level-style sram rd/we bus
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 24,
  parameter int GAP_CYCLES    = 3,
  parameter bit PRIO_B        = 1'b1
) (
  input  logic              clk_sdram,
  input  logic              init_n,
  sram_port_if.slave        port_a,
  sram_port_if.slave        port_b,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  output logic              sram_rd,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int CNT_W = $clog2(max_int(ACCESS_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  port_sel_t        sel;
  port_sel_t        rr_ptr;
  port_sel_t        win;
  logic [CNT_W-1:0] cnt;
  req_t             pend_a;
  req_t             pend_b;
  req_t             win_req;
  logic             done_a;
  logic             done_b;
  logic             both_pend;

  assign done_a    = (state == SAMPLE) && (sel == PORT_A);
  assign done_b    = (state == SAMPLE) && (sel == PORT_B);
  assign both_pend = port_a.busy && port_b.busy;

  sram_arb_port u_port_a (
    .clk_sdram   (clk_sdram),
    .init_n      (init_n),
    .req         (port_a.req),
    .we          (port_a.we),
    .addr        (port_a.addr),
    .din         (port_a.din),
    .grant_done  (done_a),
    .sample_data (sram_dout),
    .pend        (pend_a),
    .busy        (port_a.busy),
    .dout        (port_a.dout),
    .ack         (port_a.ack)
  );

  sram_arb_port u_port_b (
    .clk_sdram   (clk_sdram),
    .init_n      (init_n),
    .req         (port_b.req),
    .we          (port_b.we),
    .addr        (port_b.addr),
    .din         (port_b.din),
    .grant_done  (done_b),
    .sample_data (sram_dout),
    .pend        (pend_b),
    .busy        (port_b.busy),
    .dout        (port_b.dout),
    .ack         (port_b.ack)
  );

  // Pick the winner among registered pending requests; a strobe only counts once captured.
  always_comb begin
    win = PORT_A;
    if (both_pend) begin
      if (PRIO_B) win = PORT_B;
      else        win = rr_ptr;
    end else if (port_b.busy) begin
      win = PORT_B;
    end
    win_req = (win == PORT_B) ? pend_b : pend_a;
  end

  // Slot sequencer: grant, hold rd/we for the access slot, sample, then a low gap.
  always_ff @(posedge clk_sdram) begin
    if (!init_n) begin
      state     <= IDLE;
      sel       <= PORT_A;
      rr_ptr    <= PORT_A;
      cnt       <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_we   <= 1'b0;
      sram_rd   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (port_a.busy || port_b.busy) begin
            sel       <= win;
            sram_addr <= win_req.addr;
            sram_din  <= win_req.din;
            sram_we   <= win_req.we;
            sram_rd   <= !win_req.we;
            cnt       <= ACC_LOAD;
            state     <= SLOT;
            if (!PRIO_B && both_pend) begin
              rr_ptr <= (win == PORT_A) ? PORT_B : PORT_A;
            end
          end
        end
        SLOT: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        SAMPLE: begin
          sram_we <= 1'b0;
          sram_rd <= 1'b0;
          cnt     <= GAP_LOAD;
          state   <= GAP;
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  logic clk_sdram = 1'b0;
  always #4 clk_sdram = ~clk_sdram;

  logic        init_n;
  logic [24:0] sram_addr, r_sram_addr;
  logic [7:0]  sram_din, r_sram_din, sram_dout, r_sram_dout;
  logic        sram_we, sram_rd, r_sram_we, r_sram_rd;

  sram_port_if pa ();
  sram_port_if pb ();
  sram_port_if ra ();
  sram_port_if rb ();

  sram_port_arbiter #(.ACCESS_CYCLES(24), .GAP_CYCLES(3), .PRIO_B(1'b1)) dut (
    .clk_sdram (clk_sdram), .init_n (init_n), .port_a (pa), .port_b (pb),
    .sram_addr (sram_addr), .sram_din (sram_din), .sram_we (sram_we),
    .sram_rd (sram_rd), .sram_dout (sram_dout)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(24), .GAP_CYCLES(3), .PRIO_B(1'b0)) dut_rr (
    .clk_sdram (clk_sdram), .init_n (init_n), .port_a (ra), .port_b (rb),
    .sram_addr (r_sram_addr), .sram_din (r_sram_din), .sram_we (r_sram_we),
    .sram_rd (r_sram_rd), .sram_dout (r_sram_dout)
  );

  assign r_sram_dout = r_sram_addr[7:0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural sram: 2-FF sync on rd/we, edge detect, random read return delay.
  logic [7:0]  mem [256];
  logic [2:0]  rd_s, we_s;
  logic        rd_pend;
  int          rd_cnt;
  logic [7:0]  rd_idx;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h23] = 8'h5A;
    rd_s = '0; we_s = '0; rd_pend = 1'b0; rd_cnt = 0; rd_idx = '0;
    sram_dout = 8'h00;
  end

  always @(posedge clk_sdram) begin
    rd_s <= {rd_s[1:0], sram_rd};
    we_s <= {we_s[1:0], sram_we};
    if (we_s[1] && !we_s[2]) mem[sram_addr[7:0]] <= sram_din;
    if (rd_s[1] && !rd_s[2]) begin
      rd_pend <= 1'b1;
      rd_cnt  <= int'($urandom_range(0, 18));
      rd_idx  <= sram_addr[7:0];
    end else if (rd_pend) begin
      if (rd_cnt == 0) begin
        sram_dout <= mem[rd_idx];
        rd_pend   <= 1'b0;
      end else begin
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  // Bus monitor: length of each rd/we pulse and whether addr/din/we stayed put.
  int          cur_len = 0, last_len = 0;
  logic        cur_stable = 1'b0, last_stable = 1'b0;
  logic [24:0] cap_addr = '0;
  logic [7:0]  cap_din = '0;
  logic        cap_we = 1'b0;

  always @(negedge clk_sdram) begin
    if (!init_n) begin
      cur_len <= 0;
    end else if (sram_rd || sram_we) begin
      cur_len <= cur_len + 1;
      if (cur_len == 0) begin
        cap_addr   <= sram_addr;
        cap_din    <= sram_din;
        cap_we     <= sram_we;
        cur_stable <= !(sram_rd && sram_we);
      end else if (sram_addr != cap_addr || sram_din != cap_din || sram_we != cap_we
                   || (sram_rd && sram_we)) begin
        cur_stable <= 1'b0;
      end
    end else if (cur_len != 0) begin
      last_len    <= cur_len;
      last_stable <= cur_stable;
      cur_len     <= 0;
    end
  end

  task automatic access(input bit port_b, input bit we, input logic [24:0] addr,
                        input logic [7:0] din, output int lat, output logic [7:0] dout,
                        output logic busy_at_ack);
    bit got;
    @(negedge clk_sdram);
    if (port_b) begin pb.req = 1'b1; pb.we = we; pb.addr = addr; pb.din = din; end
    else        begin pa.req = 1'b1; pa.we = we; pa.addr = addr; pa.din = din; end
    lat = 0; got = 1'b0; dout = '0; busy_at_ack = 1'b1;
    while (!got && lat < 200) begin
      @(negedge clk_sdram);
      pa.req = 1'b0; pb.req = 1'b0;
      lat++;
      if (port_b ? pb.ack : pa.ack) begin
        got = 1'b1;
        dout = port_b ? pb.dout : pa.dout;
        busy_at_ack = port_b ? pb.busy : pa.busy;
      end
    end
  endtask

  typedef struct {
    bit          port_b;
    bit          we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, hi, t_a, t_b, cyc, n;
    logic [7:0]  dout;
    logic        bsy;
    bit          order [6];

    vecs[0] = '{0, 0, 25'h0000123, 8'h00, 8'h5A};
    vecs[1] = '{0, 1, 25'h1FFFFFF, 8'hC3, 8'h5A};
    vecs[2] = '{0, 0, 25'h1FFFFFF, 8'h00, 8'hC3};
    vecs[3] = '{1, 0, 25'h0000123, 8'h00, 8'h5A};
    vecs[4] = '{1, 1, 25'h00000AA, 8'h3C, 8'h5A};
    vecs[5] = '{1, 0, 25'h00000AA, 8'h00, 8'h3C};
    vecs[6] = '{0, 0, 25'h00000AA, 8'h00, 8'h3C};
    vecs[7] = '{0, 0, 25'h00000AA, 8'h00, 8'h3C};

    pa.req = 0; pa.we = 0; pa.addr = '0; pa.din = '0;
    pb.req = 0; pb.we = 0; pb.addr = '0; pb.din = '0;
    ra.req = 0; ra.we = 0; ra.addr = '0; ra.din = '0;
    rb.req = 0; rb.we = 0; rb.addr = '0; rb.din = '0;
    init_n = 1'b0;

    repeat (5) @(negedge clk_sdram);
    check("rst_a_outs", {pa.dout, pa.ack, pa.busy}, 32'h0);
    check("rst_b_outs", {pb.dout, pb.ack, pb.busy}, 32'h0);
    check("rst_sram_addr", sram_addr, 32'h0);
    check("rst_sram_ctl", {sram_din, sram_we, sram_rd}, 32'h0);

    init_n = 1'b1;
    hi = 0;
    repeat (100) begin
      @(negedge clk_sdram);
      if (sram_rd || sram_we || r_sram_rd || r_sram_we) hi++;
    end
    check("idle_bus_quiet", hi, 0);

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].port_b, vecs[i].we, vecs[i].addr, vecs[i].din, lat, dout, bsy);
      check($sformatf("v%0d_latency", i), lat, 27);
      check($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("v%0d_busy_at_ack", i), bsy, 0);
      repeat (5) @(negedge clk_sdram);
      check($sformatf("v%0d_strobe_len", i), last_len, 25);
      check($sformatf("v%0d_bus_stable", i), last_stable, 1);
      check($sformatf("v%0d_bus_we", i), cap_we, vecs[i].we);
      check($sformatf("v%0d_bus_addr", i), cap_addr, vecs[i].addr);
      check($sformatf("v%0d_bus_din", i), cap_din, vecs[i].din);
    end

    // Fixed priority conflict: B first, A one slot period later.
    @(negedge clk_sdram);
    pa.req = 1; pa.we = 0; pa.addr = 25'h0000123;
    pb.req = 1; pb.we = 0; pb.addr = 25'h00000AA;
    t_a = 0; t_b = 0; cyc = 0;
    while (t_a == 0 && cyc < 150) begin
      @(negedge clk_sdram);
      pa.req = 0; pb.req = 0;
      cyc++;
      if (pb.ack) t_b = cyc;
      if (pa.ack) begin
        t_a = cyc;
        check("conf_b_dout_kept", pb.dout, 8'h3C);
        check("conf_a_dout", pa.dout, 8'h5A);
      end
    end
    check("conf_b_ack_cycle", t_b, 27);
    check("conf_a_after_b", t_a - t_b, 29);
    repeat (5) @(negedge clk_sdram);

    // Round-robin: both ports re-strobe on their own ack.
    @(negedge clk_sdram);
    ra.req = 1; ra.we = 0; ra.addr = 25'h0000011;
    rb.req = 1; rb.we = 0; rb.addr = 25'h0000022;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 400) begin
      @(negedge clk_sdram);
      cyc++;
      ra.req = ra.ack;
      rb.req = rb.ack;
      if (ra.ack && n < 6) begin order[n] = 1'b0; n++; end
      if (rb.ack && n < 6) begin order[n] = 1'b1; n++; end
    end
    @(negedge clk_sdram);
    ra.req = 0; rb.req = 0;
    check("rr_ack_count", n, 6);
    for (int k = 0; k < 6; k++) check($sformatf("rr_grant%0d", k), order[k], k % 2);
    cyc = 0;
    while ((ra.busy || rb.busy) && cyc < 200) begin @(negedge clk_sdram); cyc++; end
    check("rr_drained", {ra.busy, rb.busy}, 0);
    check("rr_a_dout", ra.dout, 8'h11);
    check("rr_b_dout", rb.dout, 8'h22);
    repeat (5) @(negedge clk_sdram);

    // Reset in the middle of a B read.
    @(negedge clk_sdram);
    pb.req = 1; pb.we = 0; pb.addr = 25'h0000123;
    @(negedge clk_sdram);
    pb.req = 0;
    repeat (9) @(negedge clk_sdram);
    check("mid_rd_high", sram_rd, 1);
    init_n = 1'b0;
    @(negedge clk_sdram);
    check("mid_rd_dropped", sram_rd, 0);
    check("mid_b_busy", pb.busy, 0);
    check("mid_b_dout", pb.dout, 0);
    init_n = 1'b1;
    hi = 0;
    repeat (40) begin
      @(negedge clk_sdram);
      if (pb.ack || pa.ack || sram_rd || sram_we) hi++;
    end
    check("mid_no_ack", hi, 0);
    access(1'b1, 1'b0, 25'h00000AA, 8'h00, lat, dout, bsy);
    check("post_rst_latency", lat, 27);
    check("post_rst_dout", dout, 8'h3C);
    check("post_rst_busy", bsy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
